// File: rtl/ram_port_arbiter_if.sv
// Requester ports A/B plus the smallRAM side of ram_port_arbiter, bundled as one interface.
// slave = the arbiter itself; master = everything around it (requesters and the RAM).
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_wr;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_wr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic              ram_cs;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_do;

    logic              busy;

    modport slave (
        input  a_req, a_wr, a_addr, a_wdata,
        input  b_req, b_wr, b_addr, b_wdata,
        input  ram_do,
        output a_ack, a_rdata, b_ack, b_rdata,
        output ram_cs, ram_wr, ram_addr, ram_di,
        output busy
    );

    modport master (
        output a_req, a_wr, a_addr, a_wdata,
        output b_req, b_wr, b_addr, b_wdata,
        output ram_do,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  ram_cs, ram_wr, ram_addr, ram_di,
        input  busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer serialising single-beat reads and writes onto the 64x8 smallRAM.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise port A wins every tie.
module ram_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    state_e            state_q, state_d;
    port_e             grant_q, grant_d;
    logic              ram_cs_q, ram_cs_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_di_q, ram_di_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              busy_q, busy_d;
`ifdef RAM_ARB_RR_EN
    port_e             last_grant_q, last_grant_d;
`endif

    port_e             winner;
    logic              any_req;

    // Tie-break between simultaneous requests; a lone requester always wins.
    always_comb begin
        any_req = bus.a_req | bus.b_req;
`ifdef RAM_ARB_RR_EN
        if (bus.a_req && bus.b_req) begin
            winner = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
        end else if (bus.a_req) begin
            winner = PORT_A;
        end else begin
            winner = PORT_B;
        end
`else
        winner = bus.a_req ? PORT_A : PORT_B;
`endif
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ram_cs_d   = 1'b0;
        ram_wr_d   = ram_wr_q;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
`ifdef RAM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d  = winner;
                    ram_cs_d = 1'b1;
                    if (winner == PORT_A) begin
                        ram_wr_d   = bus.a_wr;
                        ram_addr_d = bus.a_addr;
                        ram_di_d   = bus.a_wdata;
                    end else begin
                        ram_wr_d   = bus.b_wr;
                        ram_addr_d = bus.b_addr;
                        ram_di_d   = bus.b_wdata;
                    end
`ifdef RAM_ARB_RR_EN
                    last_grant_d = winner;
`endif
                    state_d = ISSUE;
                end
            end

            // The RAM acts on the edge closing this cycle, so a write can be acked right away.
            ISSUE: begin
                ram_wr_d = 1'b0;
                if (ram_wr_q) begin
                    a_ack_d = (grant_q == PORT_A);
                    b_ack_d = (grant_q == PORT_B);
                    state_d = ACK;
                end else begin
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (grant_q == PORT_A) begin
                    a_rdata_d = bus.ram_do;
                    a_ack_d   = 1'b1;
                end else begin
                    b_rdata_d = bus.ram_do;
                    b_ack_d   = 1'b1;
                end
                state_d = ACK;
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= PORT_A;
            ram_cs_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_di_q   <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            busy_q     <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_grant_q <= PORT_B;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ram_cs_q   <= ram_cs_d;
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            busy_q     <= busy_d;
`ifdef RAM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.ram_cs   = ram_cs_q;
    assign bus.ram_wr   = ram_wr_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_di   = ram_di_q;
    assign bus.a_ack    = a_ack_q;
    assign bus.b_ack    = b_ack_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, reset corner cases, contention,
// and random traffic checked against a transaction-level model of the arbiter.
module tb_ram_port_arbiter;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in for smallRAM: synchronous write, registered read data.
    logic [DATA_W-1:0] ramMem [64] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_wr) ramMem[bus.ram_addr] <= bus.ram_di;
            else            bus.ram_do <= ramMem[bus.ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] lastRd [2] = '{8'h00, 8'h00};
    logic [DATA_W-1:0] mMem [64] = '{default: 8'h00};

    typedef struct {
        bit                port;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                ackCycle;
        logic [DATA_W-1:0] expRdata;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit port, input logic req, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (!port) begin
            bus.a_req = req; bus.a_wr = wr; bus.a_addr = addr; bus.a_wdata = wdata;
        end else begin
            bus.b_req = req; bus.b_wr = wr; bus.b_addr = addr; bus.b_wdata = wdata;
        end
    endtask

    function automatic logic portAck(input bit p);
        return p ? bus.b_ack : bus.a_ack;
    endfunction

    function automatic logic [DATA_W-1:0] portRdata(input bit p);
        return p ? bus.b_rdata : bus.a_rdata;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cs"},      bus.ram_cs,   0);
        checkOutput({tag, "_wr"},      bus.ram_wr,   0);
        checkOutput({tag, "_addr"},    bus.ram_addr, 0);
        checkOutput({tag, "_di"},      bus.ram_di,   0);
        checkOutput({tag, "_a_ack"},   bus.a_ack,    0);
        checkOutput({tag, "_b_ack"},   bus.b_ack,    0);
        checkOutput({tag, "_a_rdata"}, bus.a_rdata,  0);
        checkOutput({tag, "_b_rdata"}, bus.b_rdata,  0);
        checkOutput({tag, "_busy"},    bus.busy,     0);
    endtask

    // One isolated transaction, checked cycle by cycle against the vector's latency.
    task automatic runVector(input vec_t v);
        bit other;
        other = ~v.port;
        @(posedge clk); #1;
        applyStimulus(v.port, 1'b1, v.wr, v.addr, v.wdata);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            checkOutput("vec_cs", bus.ram_cs, (c == 1));
            if (c == 1) begin
                checkOutput("vec_wr",   bus.ram_wr,   v.wr);
                checkOutput("vec_addr", bus.ram_addr, v.addr);
                if (v.wr) checkOutput("vec_di", bus.ram_di, v.wdata);
            end
            checkOutput("vec_busy",        bus.busy,         (c <= v.ackCycle));
            checkOutput("vec_ack",         portAck(v.port),  (c == v.ackCycle));
            checkOutput("vec_other_ack",   portAck(other),   0);
            checkOutput("vec_other_rdata", portRdata(other), lastRd[other]);
            if (c == v.ackCycle) begin
                if (!v.wr) lastRd[v.port] = v.expRdata;
                checkOutput("vec_rdata", portRdata(v.port), lastRd[v.port]);
                applyStimulus(v.port, 1'b0, 1'b0, '0, '0);
            end
        end
    endtask

    // Random traffic; the model tracks each transaction by its start cycle and fixed latency.
    task automatic runRandom(input int nCycles);
        bit mActive = 1'b0;
        int mStart = 0;
        bit mPort = 1'b0;
        logic mWr = 1'b0;
        logic [ADDR_W-1:0] mAddr = '0;
        logic [DATA_W-1:0] mData = '0;
`ifdef RAM_ARB_RR_EN
        bit mLast = 1'b1;
`endif
        bit pend [2] = '{1'b0, 1'b0};
        logic pWr [2] = '{1'b0, 1'b0};
        logic [ADDR_W-1:0] pAddr [2] = '{'0, '0};
        logic [DATA_W-1:0] pData [2] = '{'0, '0};
        logic [DATA_W-1:0] mRd [2] = '{8'h00, 8'h00};
        int d, lat;
        logic expCs, expWr, expBusy;
        logic expAck [2];
        bit g;
        for (int k = 0; k < nCycles; k++) begin
            @(posedge clk); #1;
            expCs = 1'b0; expWr = 1'b0; expBusy = 1'b0;
            expAck[0] = 1'b0; expAck[1] = 1'b0;
            if (mActive) begin
                d = k - mStart;
                lat = mWr ? 2 : 3;
                if (d == 1) begin expCs = 1'b1; expWr = mWr; end
                if (d == 2 && mWr) mMem[mAddr] = mData;
                if (d == lat) begin
                    expAck[mPort] = 1'b1;
                    if (!mWr) mRd[mPort] = mMem[mAddr];
                    pend[mPort] = 1'b0;
                end
                expBusy = (d >= 1) && (d <= lat);
                if (d > lat) mActive = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[p]  = 1'b1;
                        pWr[p]   = 1'($urandom_range(0, 1));
                        pAddr[p] = ($urandom_range(0, 3) == 0) ? ADDR_W'(63) : ADDR_W'($urandom_range(0, 7));
                        pData[p] = DATA_W'($urandom);
                        applyStimulus(p[0], 1'b1, pWr[p], pAddr[p], pData[p]);
                    end else begin
                        applyStimulus(p[0], 1'b0, 1'b0, '0, '0);
                    end
                end
            end
            if (!mActive && (pend[0] || pend[1])) begin
`ifdef RAM_ARB_RR_EN
                g = (pend[0] && pend[1]) ? ~mLast : pend[1];
                mLast = g;
`else
                g = pend[0] ? 1'b0 : 1'b1;
`endif
                mActive = 1'b1; mStart = k; mPort = g;
                mWr = pWr[g]; mAddr = pAddr[g]; mData = pData[g];
            end
            @(negedge clk);
            checkOutput("rnd_cs",      bus.ram_cs,  expCs);
            checkOutput("rnd_wr",      bus.ram_wr,  expWr);
            checkOutput("rnd_busy",    bus.busy,    expBusy);
            checkOutput("rnd_a_ack",   bus.a_ack,   expAck[0]);
            checkOutput("rnd_b_ack",   bus.b_ack,   expAck[1]);
            checkOutput("rnd_a_rdata", bus.a_rdata, mRd[0]);
            checkOutput("rnd_b_rdata", bus.b_rdata, mRd[1]);
            if (expCs) begin
                checkOutput("rnd_addr", bus.ram_addr, mAddr);
                if (mWr) checkOutput("rnd_di", bus.ram_di, mData);
            end
        end
    endtask

    initial begin
        vec_t vecs [6];
        vec_t rdAfterRst;
        bit expOrder [5];
        int nExp;
        int nAcks;
        int budget;

        vecs[0] = '{1'b0, 1'b1, 6'd5,  8'h2A, 2, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 6'd5,  8'h00, 3, 8'h2A};
        vecs[2] = '{1'b0, 1'b1, 6'd63, 8'hFF, 2, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 6'd0,  8'h01, 2, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 6'd63, 8'h00, 3, 8'hFF};
        vecs[5] = '{1'b0, 1'b0, 6'd0,  8'h00, 3, 8'h01};

        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);

        #12;
        checkAllZero("reset");
        @(posedge clk); #1 rst = 1'b0;

        $display("[TB] random traffic");
        runRandom(400);

        // Asynchronous reset in the middle of live random traffic.
        @(posedge clk); #2 rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        checkAllZero("held_rst");
        rst = 1'b0;
        lastRd[0] = '0; lastRd[1] = '0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 6; i++) runVector(vecs[i]);

        $display("[TB] reset during RD_WAIT");
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 8'h00);
        @(posedge clk); #1;
        checkOutput("rdw_cs", bus.ram_cs, 1);
        @(posedge clk); #1;
        checkOutput("rdw_busy", bus.busy, 1);
        checkOutput("rdw_ack", bus.a_ack, 0);
        #1 rst = 1'b1;
        #1;
        checkAllZero("rdw_rst");
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lastRd[0] = '0; lastRd[1] = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("rdw_post_ack",   bus.a_ack,   0);
            checkOutput("rdw_post_rdata", bus.a_rdata, 0);
            checkOutput("rdw_post_busy",  bus.busy,    0);
        end
        rdAfterRst = '{1'b0, 1'b0, 6'd0, 8'h00, 3, 8'h01};
        runVector(rdAfterRst);

        $display("[TB] contention");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
`ifdef RAM_ARB_RR_EN
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        nExp = 4;
`else
        expOrder = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        nExp = 5;
`endif
        nAcks = 0;
        budget = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd5,  8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd63, 8'h00);
        while (nAcks < nExp && budget < 60) begin
            @(posedge clk); #1;
            budget++;
            if (bus.a_ack || bus.b_ack) begin
                checkOutput("grant_single", bus.a_ack & bus.b_ack, 0);
                checkOutput("grant_order",  bus.b_ack, expOrder[nAcks]);
                if (bus.b_ack) checkOutput("grant_b_rdata", bus.b_rdata, 8'hFF);
                else           checkOutput("grant_a_rdata", bus.a_rdata, 8'h2A);
                nAcks++;
                if (nAcks == 4) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
                if (nAcks == nExp) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
        checkOutput("contention_acks", nAcks, nExp);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
